max_scan_accumulator: RTL and testbench
=======================================

MAX_SCAN_ACCUMULATOR -- requirements
Module: max_scan_accumulator

Interface
REQ-001 Parameter VALUE_SIZE, default 4, width of candidate payload.
REQ-002 Parameter DISCRIMINANT_SIZE, default 4, width of candidate priority key.
REQ-003 Parameter COUNT_SIZE, default 8, width of batch beat counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  candidate beat present.
REQ-007 in_ready  output  1  block accepts a candidate beat this cycle.
REQ-008 in_value  input  VALUE_SIZE  candidate payload.
REQ-009 in_discriminant  input  DISCRIMINANT_SIZE  candidate key.
REQ-010 in_last  input  1  beat closes the current batch.
REQ-011 out_valid  output  1  batch result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_value  output  VALUE_SIZE  payload of batch winner.
REQ-014 out_discriminant  output  DISCRIMINANT_SIZE  key of batch winner.
REQ-015 out_count  output  COUNT_SIZE  beats accepted in the batch.

Function
REQ-016 A beat is accepted when in_valid and in_ready are both high on a rising edge; a result is consumed when out_valid and out_ready are both high.
REQ-017 FSM states: IDLE, ACCUM, HOLD; in_ready = 1 in IDLE and ACCUM, 0 in HOLD; out_valid = 1 only in HOLD.
REQ-018 IDLE, beat accepted: best value/key loaded unconditionally from the beat, count = 1; next state HOLD if in_last, else ACCUM.
REQ-019 ACCUM, beat accepted: best replaced when in_discriminant > best key OR equal (tie goes to later beat); otherwise best kept; count incremented.
REQ-020 ACCUM, beat accepted with in_last: the beat takes part in the comparison, then next state HOLD.
REQ-021 Comparison is unsigned over DISCRIMINANT_SIZE bits.
REQ-022 Count saturates at 2^COUNT_SIZE-1; further beats are still compared.
REQ-023 Latency: out_valid high on the cycle after the in_last beat is accepted; single-beat batch gives the same one-cycle latency.
REQ-024 HOLD: out_value, out_discriminant and out_count stable until consumed; out_ready consumption -> IDLE next cycle.
REQ-025 in_valid low in IDLE/ACCUM: no state change; gaps between beats are allowed.
REQ-026 out_ready while out_valid low has no effect.
REQ-027 Throughput: one beat per cycle inside a batch; one idle-accept bubble per batch is not required, but the next batch's first beat is not accepted before the HOLD->IDLE transition.

Reset
REQ-028 reset high: state IDLE, best value/key = 0, count = 0, out_valid = 0, in_ready = 1 on the following cycle.
REQ-029 reset overrides any simultaneous beat or consumption; a batch in progress or a held result is discarded with no output.
REQ-030 Outputs out_value, out_discriminant, out_count read 0 after reset until the first result.

Configuration
REQ-031 Macro MAX_SCAN_INDEX_EN defined: extra output out_index (COUNT_SIZE bits) gives 0-based beat position of the winner in its batch, updated with the winner, saturating like count, 0 on reset.
REQ-032 Macro MAX_SCAN_INDEX_EN undefined: out_index port and its register are absent; all other behaviour identical.

Verification
REQ-033 Batch keys 3,9,5 (values A,B,C), last on 3rd beat -> next cycle out_valid=1, out_value=B, out_discriminant=9, out_count=3, out_index=1.
REQ-034 Batch keys 7,7 (values A,B) -> out_value=B, out_discriminant=7, out_count=2 (tie to later beat).
REQ-035 Single beat key 0 value D with in_last -> out_valid next cycle, out_value=D, out_count=1; out_ready held low 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-036 Reset asserted during ACCUM after 2 beats -> no out_valid, all outputs 0, in_ready=1; new batch keys 2,1 -> out_discriminant=2, out_count=2.
REQ-037 COUNT_SIZE=2, batch of 5 beats keys 1,2,3,4,15 -> out_count=3, out_discriminant=15, out_index=3 with MAX_SCAN_INDEX_EN.
REQ-038 Back-to-back batches, in_valid held high with out_ready high -> every result correct, no beat lost or duplicated.

Source files
------------

// File: rtl/max_scan_accumulator.sv
// max_scan_accumulator: scans a batch of candidate beats and reports the beat with
// the largest unsigned key (ties go to the later beat) together with the batch size.
// Optional feature: define MAX_SCAN_INDEX_EN to add out_index, the 0-based position
// of the winning beat inside its batch.
module max_scan_accumulator #(
  parameter int unsigned VALUE_SIZE        = 4,
  parameter int unsigned DISCRIMINANT_SIZE = 4,
  parameter int unsigned COUNT_SIZE        = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [VALUE_SIZE-1:0]        in_value,
  input  logic [DISCRIMINANT_SIZE-1:0] in_discriminant,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [VALUE_SIZE-1:0]        out_value,
  output logic [DISCRIMINANT_SIZE-1:0] out_discriminant,
`ifdef MAX_SCAN_INDEX_EN
  output logic [COUNT_SIZE-1:0]        out_index,
`endif
  output logic [COUNT_SIZE-1:0]        out_count
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e state_q, state_d;

  // Running best of the batch in progress.
  logic [VALUE_SIZE-1:0]        best_value_q, best_value_d;
  logic [DISCRIMINANT_SIZE-1:0] best_disc_q, best_disc_d;
  logic [COUNT_SIZE-1:0]        count_q, count_d;

  // Published result; only written when a batch closes, so the outputs stay at
  // zero after reset until the first result and never expose a partial batch.
  logic [VALUE_SIZE-1:0]        res_value_q;
  logic [DISCRIMINANT_SIZE-1:0] res_disc_q;
  logic [COUNT_SIZE-1:0]        res_count_q;

`ifdef MAX_SCAN_INDEX_EN
  logic [COUNT_SIZE-1:0]        best_index_q, best_index_d;
  logic [COUNT_SIZE-1:0]        res_index_q;
`endif

  logic accept;
  logic close_batch;
  logic cand_wins;
  logic [COUNT_SIZE-1:0] count_inc;

  assign accept      = in_valid && in_ready;
  assign close_batch = accept && in_last;

  // First beat of a batch wins unconditionally; later beats win on >= (tie to later).
  assign cand_wins = (state_q == StIdle) || (in_discriminant >= best_disc_q);

  // Saturating increment; in ACCUM count_q also equals the 0-based position of the
  // incoming beat, saturated the same way.
  assign count_inc = (count_q == {COUNT_SIZE{1'b1}}) ? count_q : count_q + COUNT_SIZE'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = in_last ? StHold : StAccum;
      end
      StAccum: begin
        if (accept && in_last) state_d = StHold;
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle:  in_ready  = 1'b1;
      StAccum: in_ready  = 1'b1;
      StHold:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Next value of the running best and beat counter.
  always_comb begin
    best_value_d = best_value_q;
    best_disc_d  = best_disc_q;
    count_d      = count_q;
`ifdef MAX_SCAN_INDEX_EN
    best_index_d = best_index_q;
`endif
    if (accept) begin
      if (cand_wins) begin
        best_value_d = in_value;
        best_disc_d  = in_discriminant;
`ifdef MAX_SCAN_INDEX_EN
        best_index_d = (state_q == StIdle) ? '0 : count_q;
`endif
      end
      count_d = (state_q == StIdle) ? COUNT_SIZE'(1) : count_inc;
    end
  end

  // Running-best registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      best_value_q <= '0;
      best_disc_q  <= '0;
      count_q      <= '0;
`ifdef MAX_SCAN_INDEX_EN
      best_index_q <= '0;
`endif
    end else begin
      best_value_q <= best_value_d;
      best_disc_q  <= best_disc_d;
      count_q      <= count_d;
`ifdef MAX_SCAN_INDEX_EN
      best_index_q <= best_index_d;
`endif
    end
  end

  // Result registers capture the final winner, including the closing beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_value_q <= '0;
      res_disc_q  <= '0;
      res_count_q <= '0;
`ifdef MAX_SCAN_INDEX_EN
      res_index_q <= '0;
`endif
    end else if (close_batch) begin
      res_value_q <= best_value_d;
      res_disc_q  <= best_disc_d;
      res_count_q <= count_d;
`ifdef MAX_SCAN_INDEX_EN
      res_index_q <= best_index_d;
`endif
    end
  end

  assign out_value        = res_value_q;
  assign out_discriminant = res_disc_q;
  assign out_count        = res_count_q;
`ifdef MAX_SCAN_INDEX_EN
  assign out_index        = res_index_q;
`endif

endmodule

// File: tb/tb_max_scan_accumulator.sv
// Directed testbench for max_scan_accumulator. Two instances share the stimulus:
// dut uses default parameters, dut2 uses COUNT_SIZE=2 for the saturation case.
// Define MAX_SCAN_INDEX_EN to also check out_index.
module tb_max_scan_accumulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_value;
  logic [3:0] in_discriminant;
  logic       in_last;
  logic       out_ready;

  logic       in_ready, out_valid;
  logic [3:0] out_value, out_discriminant;
  logic [7:0] out_count;
  logic       in_ready2, out_valid2;
  logic [3:0] out_value2, out_discriminant2;
  logic [1:0] out_count2;
`ifdef MAX_SCAN_INDEX_EN
  logic [7:0] out_index;
  logic [1:0] out_index2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  max_scan_accumulator dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_value         (in_value),
    .in_discriminant  (in_discriminant),
    .in_last          (in_last),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_value        (out_value),
    .out_discriminant (out_discriminant),
`ifdef MAX_SCAN_INDEX_EN
    .out_index        (out_index),
`endif
    .out_count        (out_count)
  );

  max_scan_accumulator #(.COUNT_SIZE(2)) dut2 (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready2),
    .in_value         (in_value),
    .in_discriminant  (in_discriminant),
    .in_last          (in_last),
    .out_valid        (out_valid2),
    .out_ready        (out_ready),
    .out_value        (out_value2),
    .out_discriminant (out_discriminant2),
`ifdef MAX_SCAN_INDEX_EN
    .out_index        (out_index2),
`endif
    .out_count        (out_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat for one cycle; caller guarantees in_ready is high.
  task automatic beat(input logic [3:0] v, input logic [3:0] d, input logic last);
    chk("beat_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid        = 1'b1;
    in_value        = v;
    in_discriminant = d;
    in_last         = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("consumed_out_valid", {31'd0, out_valid}, 32'd0);
    chk("consumed_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // Back-to-back stream: three batches.
  logic [3:0] s_val [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
  logic [3:0] s_key [6] = '{4'd4, 4'd8, 4'd8, 4'd15, 4'd0, 4'd1};
  logic       s_last[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [3:0] r_val [3] = '{4'd3, 4'd4, 4'd6};
  logic [3:0] r_key [3] = '{4'd8, 4'd15, 4'd1};
  logic [7:0] r_cnt [3] = '{8'd3, 8'd1, 8'd2};

  initial begin
    int idx;
    int nres;
    int cyc;
    logic commit;

    reset = 1'b1; in_valid = 1'b0; in_value = '0; in_discriminant = '0;
    in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_value", {28'd0, out_value}, 32'd0);
    chk("rst_out_disc", {28'd0, out_discriminant}, 32'd0);
    chk("rst_out_count", {24'd0, out_count}, 32'd0);

    // out_ready while idle has no effect.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_ready_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_ready_in_ready", {31'd0, in_ready}, 32'd1);

    // Keys 3,9,5 -> winner B key 9, count 3, index 1.
    beat(4'hA, 4'd3, 1'b0);
    beat(4'hB, 4'd9, 1'b0);
    beat(4'hC, 4'd5, 1'b1);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t1_value", {28'd0, out_value}, 32'hB);
    chk("t1_disc", {28'd0, out_discriminant}, 32'd9);
    chk("t1_count", {24'd0, out_count}, 32'd3);
`ifdef MAX_SCAN_INDEX_EN
    chk("t1_index", {24'd0, out_index}, 32'd1);
`endif
    consume();

    // Tie 7,7 -> later beat wins.
    beat(4'hA, 4'd7, 1'b0);
    beat(4'hB, 4'd7, 1'b1);
    chk("t2_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_value", {28'd0, out_value}, 32'hB);
    chk("t2_disc", {28'd0, out_discriminant}, 32'd7);
    chk("t2_count", {24'd0, out_count}, 32'd2);
`ifdef MAX_SCAN_INDEX_EN
    chk("t2_index", {24'd0, out_index}, 32'd1);
`endif
    consume();

    // Single beat key 0, held for 5 cycles without out_ready.
    beat(4'hD, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t3_value", {28'd0, out_value}, 32'hD);
      chk("t3_disc", {28'd0, out_discriminant}, 32'd0);
      chk("t3_count", {24'd0, out_count}, 32'd1);
      @(posedge clk); #1;
    end
    consume();

    // Reset mid-batch discards it.
    beat(4'd1, 4'd5, 1'b0);
    beat(4'd2, 4'd6, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t4_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t4_rst_value", {28'd0, out_value}, 32'd0);
    chk("t4_rst_disc", {28'd0, out_discriminant}, 32'd0);
    chk("t4_rst_count", {24'd0, out_count}, 32'd0);
    @(posedge clk); #1;
    chk("t4_no_result", {31'd0, out_valid}, 32'd0);
    beat(4'd3, 4'd2, 1'b0);
    beat(4'd4, 4'd1, 1'b1);
    chk("t4_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t4_value", {28'd0, out_value}, 32'd3);
    chk("t4_disc", {28'd0, out_discriminant}, 32'd2);
    chk("t4_count", {24'd0, out_count}, 32'd2);
    consume();

    // Five beats keys 1,2,3,4,15: 2-bit count saturates at 3.
    beat(4'd1, 4'd1, 1'b0);
    beat(4'd2, 4'd2, 1'b0);
    beat(4'd3, 4'd3, 1'b0);
    beat(4'd4, 4'd4, 1'b0);
    beat(4'd5, 4'd15, 1'b1);
    chk("t5_out_valid2", {31'd0, out_valid2}, 32'd1);
    chk("t5_count2", {30'd0, out_count2}, 32'd3);
    chk("t5_disc2", {28'd0, out_discriminant2}, 32'd15);
    chk("t5_value2", {28'd0, out_value2}, 32'd5);
    chk("t5_count", {24'd0, out_count}, 32'd5);
`ifdef MAX_SCAN_INDEX_EN
    chk("t5_index2", {30'd0, out_index2}, 32'd3);
    chk("t5_index", {24'd0, out_index}, 32'd4);
`endif
    consume();

    // Back-to-back batches with in_valid and out_ready held high.
    idx = 0; nres = 0; cyc = 0;
    out_ready       = 1'b1;
    in_valid        = 1'b1;
    in_value        = s_val[0];
    in_discriminant = s_key[0];
    in_last         = s_last[0];
    while ((idx < 6 || nres < 3) && cyc < 60) begin
      @(negedge clk);
      if (out_valid) begin
        if (nres < 3) begin
          chk("t6_value", {28'd0, out_value}, {28'd0, r_val[nres]});
          chk("t6_disc", {28'd0, out_discriminant}, {28'd0, r_key[nres]});
          chk("t6_count", {24'd0, out_count}, {24'd0, r_cnt[nres]});
        end
        nres++;
      end
      commit = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (commit) idx++;
      if (idx < 6) begin
        in_value        = s_val[idx];
        in_discriminant = s_key[idx];
        in_last         = s_last[idx];
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
    end
    chk("t6_beats_sent", idx, 32'd6);
    chk("t6_results", nres, 32'd3);
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("t6_end_out_valid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
